// File: rtl/result_drain.sv
// Drains a contiguous address range from the two SRAM banks and streams each
// {bank A, bank B} word out as one 64-bit beat through a small output FIFO.
module result_drain #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        rd_start_addr,
    input  logic [ADDR_W-1:0]        rd_end_addr,
    output logic                     read,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [DATA_W-1:0]        r_data_a,
    input  logic [DATA_W-1:0]        r_data_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MEM_WORD_SIZE-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] r_addr_reg;
    logic [ADDR_W-1:0] end_reg;
    logic              inflight_reg;
    logic              inflight_last_reg;
    logic              err_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  fifo_count_reg;
    logic [CNT_W-1:0]  reserved;

    logic pop;
    logic push;
    logic issue;
    logic at_end;
    logic bounds_ok;
    logic start_accept;

    logic [MEM_WORD_SIZE-1:0] entry_data [FIFO_DEPTH];
    logic                     entry_last [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop          = (fifo_count_reg != '0) && out_ready;
    assign push         = inflight_reg;
    // Slots already spoken for: stored beats plus the read still in flight,
    // minus the beat leaving this cycle.
    assign reserved     = fifo_count_reg + CNT_W'(inflight_reg) - CNT_W'(pop);
    assign at_end       = (r_addr_reg == end_reg);
    assign bounds_ok    = (rd_start_addr <= rd_end_addr);
    assign start_accept = (state_reg == S_IDLE) && start_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = bounds_ok ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                issue = (reserved < CNT_W'(FIFO_DEPTH));
                if (issue && at_end) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final beat is accepted so done lands the cycle after.
                if (!inflight_reg &&
                    ((fifo_count_reg == '0) || ((fifo_count_reg == CNT_W'(1)) && pop))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_addr_reg        <= '0;
            end_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue && at_end;
            if (start_accept) begin
                err_reg <= !bounds_ok;
                if (bounds_ok) begin
                    r_addr_reg <= rd_start_addr;
                    end_reg    <= rd_end_addr;
                end
            end else if (issue && !at_end) begin
                // Holding at the end address keeps 2**ADDR_W-1 from wrapping to 0.
                r_addr_reg <= r_addr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [MEM_WORD_SIZE-1:0] data_reg;
            logic                     last_reg;

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= {r_data_a, r_data_b};
                    last_reg <= inflight_last_reg;
                end
            end

            assign entry_data[gi] = data_reg;
            assign entry_last[gi] = last_reg;
        end
    endgenerate

    assign read      = ~issue;
    assign r_addr    = r_addr_reg;
    assign out_valid = (fifo_count_reg != '0);
    assign out_data  = out_valid ? entry_data[rd_ptr_reg] : '0;
    assign out_last  = out_valid ? entry_last[rd_ptr_reg] : 1'b0;
    assign busy      = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);
    assign err       = err_reg;

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: SRAM bank model, expected-beat scoreboard
// filled at start, and a negedge monitor checking reads, beats and handshakes.
module tb_result_drain;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int MW    = 64;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] rd_start_addr = '0;
    logic [AW-1:0] rd_end_addr = '0;
    logic          read;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data_a = '0;
    logic [DW-1:0] r_data_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    result_drain #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .rd_start_addr(rd_start_addr), .rd_end_addr(rd_end_addr),
        .read(read), .r_addr(r_addr), .r_data_a(r_data_a), .r_data_b(r_data_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [MW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] mem_a [1 << AW];
    logic [DW-1:0] mem_b [1 << AW];
    beat_t         exp_q[$];
    int            exp_addr_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int issued = 0;
    int accepted = 0;
    int first_read_cyc = -1;
    int first_beat_cyc = -1;
    int last_beat_cyc = -1;
    int done_cyc = -1;
    int start_c = 0;
    int ready_mode = 0;
    int ready_phase = 0;
    bit done_seen = 0;
    bit stall_prev = 0;
    logic [MW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM banks: one-cycle read latency on the active-low strobe.
    always @(posedge clk_i) begin
        if (read === 1'b0) begin
            r_data_a <= mem_a[r_addr];
            r_data_b <= mem_b[r_addr];
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                ready_phase++;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (read === 1'b0) begin
                if (first_read_cyc < 0) first_read_cyc = cyc;
                if (exp_addr_q.size() == 0) begin
                    chk("spurious_read", 64'(~read), 64'd0);
                end else begin
                    chk("read_addr", 64'(r_addr), 64'(exp_addr_q.pop_front()));
                end
                chk("fifo_room", 64'((issued - accepted - int'(out_valid && out_ready)) < DEPTH), 64'd1);
                issued++;
            end
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(out_valid), 64'd0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", out_data, b.data);
                    chk("beat_last", 64'(out_last), 64'(b.last));
                    $display("[TB] beat data=%h last=%0b", out_data, out_last);
                end
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                accepted++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic start_drain(input logic [AW-1:0] s, input logic [AW-1:0] e);
        beat_t b;
        @(posedge clk_i);
        #1;
        for (int a = int'(s); a <= int'(e); a++) begin
            b.data = {mem_a[a], mem_b[a]};
            b.last = (a == int'(e));
            exp_q.push_back(b);
            exp_addr_q.push_back(a);
        end
        first_read_cyc = -1;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        done_cyc       = -1;
        done_seen      = 1'b0;
        start_i        = 1'b1;
        rd_start_addr  = s;
        rd_end_addr    = e;
        @(posedge clk_i);
        #1;
        start_c = cyc;
        start_i = 1'b0;
        $display("[TB] drain start=%h end=%h ready_mode=%0d", s, e, ready_mode);
    endtask

    task automatic wait_done(input logic exp_err);
        for (int i = 0; i < 400 && !done_seen; i++) begin
            @(negedge clk_i);
            #1;
        end
        chk("done_seen", 64'(done_seen), 64'd1);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("reads_left", 64'(exp_addr_q.size()), 64'd0);
        chk("err", 64'(err), 64'(exp_err));
        @(negedge clk_i);
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"}, 64'(read), 64'd1);
        chk({tag, "_r_addr"}, 64'(r_addr), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int acc0;
        int iss0;
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end

        // Reset held with start asserted.
        rst_i = 1'b0;
        start_i = 1'b1;
        rd_start_addr = 9'h010;
        rd_end_addr = 9'h013;
        repeat (3) begin
            @(negedge clk_i);
            check_reset_outputs("reset_hold");
        end
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        rst_i = 1'b1;

        // Back-to-back drain at full throughput with exact latency.
        ready_mode = 0;
        start_drain(9'h010, 9'h013);
        wait_done(1'b0);
        chk("first_read_cycle", 64'(first_read_cyc - start_c + 1), 64'd1);
        chk("first_beat_cycle", 64'(first_beat_cyc - start_c + 1), 64'd3);
        chk("last_beat_cycle", 64'(last_beat_cyc - start_c + 1), 64'd6);
        chk("done_cycle", 64'(done_cyc - start_c + 1), 64'd7);

        // Same range with a 1,0,0,1 ready pattern.
        ready_mode = 1;
        ready_phase = 0;
        start_drain(9'h010, 9'h013);
        wait_done(1'b0);

        // Top-of-memory single word.
        ready_mode = 0;
        iss0 = issued;
        start_drain(9'h1FF, 9'h1FF);
        wait_done(1'b0);
        chk("top_read_count", 64'(issued - iss0), 64'd1);

        // Reversed bounds: error, no reads, no beats.
        iss0 = issued;
        start_drain(9'h020, 9'h01F);
        wait_done(1'b1);
        chk("err_no_reads", 64'(issued - iss0), 64'd0);
        chk("err_done_soon", 64'((done_cyc - start_c + 1) <= 2), 64'd1);

        // Reset in the middle of an 8-word drain.
        ready_mode = 0;
        acc0 = accepted;
        start_drain(9'h040, 9'h047);
        for (int i = 0; i < 50 && (accepted - acc0) < 2; i++) begin
            @(negedge clk_i);
            #1;
        end
        chk("mid_beats_before_reset", 64'(accepted - acc0), 64'd2);
        ready_mode = 3;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        issued = 0;
        accepted = 0;
        stall_prev = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("mid_reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        ready_mode = 0;
        acc0 = accepted;
        start_drain(9'h050, 9'h057);
        wait_done(1'b0);
        chk("post_reset_beats", 64'(accepted - acc0), 64'd8);

        // Randomized drains under random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < 8; k++) begin
                int a;
                a = $urandom_range(0, (1 << AW) - 1);
                mem_a[a] = $urandom;
                mem_b[a] = $urandom;
            end
            s = AW'($urandom_range(0, (1 << AW) - 1));
            e = AW'((int'(s) + $urandom_range(0, 11) > (1 << AW) - 1) ?
                    (1 << AW) - 1 : int'(s) + $urandom_range(0, 11));
            if ((t % 5) == 4 && s != e) begin
                logic [AW-1:0] tmp;
                tmp = s;
                s = e;
                e = tmp;
            end
            start_drain(s, e);
            wait_done(s > e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
